// File: rtl/fetch_line_queue.sv
`default_nettype none
// =============================================================================
// Module      : fetch_line_queue
// Description : Fetch stage with redirect arbitration, a one-line reuse buffer,
//               an I-cache request FSM and a circular instruction queue.
// Revision    : 1.0 - initial release
// =============================================================================
module fetch_line_queue #(
   parameter int ADDR_W   = 40,
   parameter int LINE_W   = 128,
   parameter int IQ_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] RESET_ADDRESS,
   input  logic              WB_REDIRECT,
   input  logic [ADDR_W-1:0] WB_ADDR,
   input  logic              EXE_REDIRECT,
   input  logic [ADDR_W-1:0] EXE_ADDR,
   input  logic              DEC_REDIRECT,
   input  logic [ADDR_W-1:0] DEC_ADDR,
   input  logic              FENCE_I,
   output logic              ICACHE_REQ_VALID,
   input  logic              ICACHE_REQ_READY,
   output logic [ADDR_W-1:0] ICACHE_REQ_ADDR,
   output logic              ICACHE_REQ_KILL,
   output logic              ICACHE_INVALIDATE,
   input  logic              ICACHE_RESP_VALID,
   input  logic [LINE_W-1:0] ICACHE_RESP_DATA,
   input  logic              ICACHE_RESP_XCPT,
   output logic              FETCH_VALID,
   output logic [ADDR_W-1:0] FETCH_PC,
   output logic [31:0]       FETCH_INST,
   output logic              FETCH_XCPT_MISALIGNED,
   output logic              FETCH_XCPT_IF,
   input  logic              DEC_READY
);

   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int TAG_W = ADDR_W - OFF;
   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = $clog2(IQ_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic              boot_q, boot_d;
   logic              halt_q, halt_d;
   logic              xpend_q, xpend_d;
   logic              lb_valid_q, lb_valid_d;
   logic [TAG_W-1:0]  lb_tag_q, lb_tag_d;
   logic [LINE_W-1:0] lb_data_q, lb_data_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] iq_pc_q   [IQ_DEPTH];
   logic [31:0]       iq_inst_q [IQ_DEPTH];
   logic              iq_mis_q  [IQ_DEPTH];
   logic              iq_xif_q  [IQ_DEPTH];

   logic              ext_redirect, redirect;
   logic [ADDR_W-1:0] sel_addr;
   logic              lb_hit, misaligned, miss, head_valid, pop, can_push;
   logic [31:0]       lb_word;
   logic              push;
   logic [31:0]       push_inst;
   logic              push_mis, push_xif;

   assign ext_redirect = WB_REDIRECT | EXE_REDIRECT | DEC_REDIRECT;
   assign redirect     = ext_redirect | boot_q;

   always_comb begin
      sel_addr = RESET_ADDRESS;
      if (WB_REDIRECT)       sel_addr = WB_ADDR;
      else if (EXE_REDIRECT) sel_addr = EXE_ADDR;
      else if (DEC_REDIRECT) sel_addr = DEC_ADDR;
   end

   assign lb_hit     = lb_valid_q & (lb_tag_q == fpc_q[ADDR_W-1:OFF]);
   assign misaligned = fpc_q[1:0] != 2'b00;
   // A pending fault entry blocks a re-request of the faulting line.
   assign miss       = ~lb_hit & ~halt_q & ~misaligned & ~xpend_q;
   assign lb_word    = 32'(lb_data_q >> {fpc_q[OFF-1:0], 3'b000});

   assign head_valid = count_q != '0;
   assign pop        = head_valid & DEC_READY & ~redirect;
   assign can_push   = (count_q != CNT_W'(IQ_DEPTH)) | pop;

   // Fetch PC, halt and line-buffer update
   always_comb begin
      fpc_d      = fpc_q;
      boot_d     = 1'b0;
      halt_d     = halt_q;
      xpend_d    = xpend_q;
      lb_valid_d = lb_valid_q;
      lb_tag_d   = lb_tag_q;
      lb_data_d  = lb_data_q;
      push       = 1'b0;
      push_inst  = 32'h0;
      push_mis   = 1'b0;
      push_xif   = 1'b0;
      if (redirect) begin
         fpc_d   = sel_addr;
         halt_d  = 1'b0;
         xpend_d = 1'b0;
      end else if (!halt_q && can_push) begin
         if (xpend_q) begin
            push     = 1'b1;
            push_xif = 1'b1;
            halt_d   = 1'b1;
            xpend_d  = 1'b0;
         end else if (misaligned) begin
            push     = 1'b1;
            push_mis = 1'b1;
            halt_d   = 1'b1;
         end else if (lb_hit) begin
            push      = 1'b1;
            push_inst = lb_word;
            fpc_d     = fpc_q + ADDR_W'(4);
         end
      end
      // fpc_q still names the requested line while in WAIT
      if (state_q == S_WAIT && ICACHE_RESP_VALID) begin
         if (ICACHE_RESP_XCPT) begin
            lb_valid_d = 1'b0;
            if (!redirect) xpend_d = 1'b1;
         end else begin
            lb_valid_d = 1'b1;
            lb_tag_d   = fpc_q[ADDR_W-1:OFF];
            lb_data_d  = ICACHE_RESP_DATA;
         end
      end
      if (FENCE_I) lb_valid_d = 1'b0;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (miss && !redirect) state_d = S_REQ;
         S_REQ: begin
            if (!redirect) begin
               if (!miss)                 state_d = S_IDLE;
               else if (ICACHE_REQ_READY) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ICACHE_RESP_VALID)          state_d = S_IDLE;
            else if (redirect || FENCE_I)   state_d = S_DRAIN;
         end
         S_DRAIN: if (ICACHE_RESP_VALID) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ICACHE_REQ_VALID  = (state_q == S_REQ) & ~redirect & miss;
      ICACHE_REQ_ADDR   = ICACHE_REQ_VALID ? {fpc_q[ADDR_W-1:OFF], {OFF{1'b0}}} : '0;
      ICACHE_REQ_KILL   = (state_q == S_WAIT) & ~ICACHE_RESP_VALID & (redirect | FENCE_I);
      ICACHE_INVALIDATE = FENCE_I & ~ext_redirect;
   end

   always_comb begin
      FETCH_VALID           = head_valid;
      FETCH_PC              = head_valid ? iq_pc_q[rd_ptr_q]   : '0;
      FETCH_INST            = head_valid ? iq_inst_q[rd_ptr_q] : 32'h0;
      FETCH_XCPT_MISALIGNED = head_valid & iq_mis_q[rd_ptr_q];
      FETCH_XCPT_IF         = head_valid & iq_xif_q[rd_ptr_q];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         fpc_q      <= '0;
         boot_q     <= 1'b1;
         halt_q     <= 1'b0;
         xpend_q    <= 1'b0;
         lb_valid_q <= 1'b0;
         lb_tag_q   <= '0;
         lb_data_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         boot_q     <= boot_d;
         halt_q     <= halt_d;
         xpend_q    <= xpend_d;
         lb_valid_q <= lb_valid_d;
         lb_tag_q   <= lb_tag_d;
         lb_data_q  <= lb_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            iq_pc_q[i]   <= '0;
            iq_inst_q[i] <= 32'h0;
            iq_mis_q[i]  <= 1'b0;
            iq_xif_q[i]  <= 1'b0;
         end
      end else if (push && !redirect) begin
         iq_pc_q[wr_ptr_q]   <= fpc_q;
         iq_inst_q[wr_ptr_q] <= push_inst;
         iq_mis_q[wr_ptr_q]  <= push_mis;
         iq_xif_q[wr_ptr_q]  <= push_xif;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_queue.sv
`default_nettype none
// =============================================================================
// Module      : tb_fetch_line_queue
// Description : Scoreboard bench for fetch_line_queue with a small I-cache model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_line_queue;
   localparam int ADDR_W   = 40;
   localparam int LINE_W   = 128;
   localparam int IQ_DEPTH = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [ADDR_W-1:0] RESET_ADDRESS = 40'h1000;
   logic              WB_REDIRECT = 0, EXE_REDIRECT = 0, DEC_REDIRECT = 0, FENCE_I = 0;
   logic [ADDR_W-1:0] WB_ADDR = '0, EXE_ADDR = '0, DEC_ADDR = '0;
   logic              ICACHE_REQ_VALID, ICACHE_REQ_KILL, ICACHE_INVALIDATE;
   logic              ICACHE_REQ_READY = 1'b1;
   logic [ADDR_W-1:0] ICACHE_REQ_ADDR;
   logic              ICACHE_RESP_VALID = 1'b0, ICACHE_RESP_XCPT = 1'b0;
   logic [LINE_W-1:0] ICACHE_RESP_DATA = '0;
   logic              FETCH_VALID, FETCH_XCPT_MISALIGNED, FETCH_XCPT_IF;
   logic [ADDR_W-1:0] FETCH_PC;
   logic [31:0]       FETCH_INST;
   logic              DEC_READY = 1'b0;

   fetch_line_queue #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .IQ_DEPTH(IQ_DEPTH)) dut (
      .CLK(CLK), .RST(RST), .RESET_ADDRESS(RESET_ADDRESS),
      .WB_REDIRECT(WB_REDIRECT), .WB_ADDR(WB_ADDR),
      .EXE_REDIRECT(EXE_REDIRECT), .EXE_ADDR(EXE_ADDR),
      .DEC_REDIRECT(DEC_REDIRECT), .DEC_ADDR(DEC_ADDR),
      .FENCE_I(FENCE_I),
      .ICACHE_REQ_VALID(ICACHE_REQ_VALID), .ICACHE_REQ_READY(ICACHE_REQ_READY),
      .ICACHE_REQ_ADDR(ICACHE_REQ_ADDR), .ICACHE_REQ_KILL(ICACHE_REQ_KILL),
      .ICACHE_INVALIDATE(ICACHE_INVALIDATE),
      .ICACHE_RESP_VALID(ICACHE_RESP_VALID), .ICACHE_RESP_DATA(ICACHE_RESP_DATA),
      .ICACHE_RESP_XCPT(ICACHE_RESP_XCPT),
      .FETCH_VALID(FETCH_VALID), .FETCH_PC(FETCH_PC), .FETCH_INST(FETCH_INST),
      .FETCH_XCPT_MISALIGNED(FETCH_XCPT_MISALIGNED), .FETCH_XCPT_IF(FETCH_XCPT_IF),
      .DEC_READY(DEC_READY)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       inst;
      logic              mis;
      logic              xif;
   } ent_t;

   ent_t              exp_q[$];
   logic [ADDR_W-1:0] req_log[$];
   int                checks = 0;
   int                passes = 0;
   int                resp_delay = 2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
   endtask

   // Memory image: word at byte address a reads 0xA00 followed by a[19:0]
   function automatic logic [LINE_W-1:0] line_data(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] d;
      logic [ADDR_W-1:0] wa;
      d = '0;
      for (int i = 0; i < LINE_W / 32; i++) begin
         wa = a + ADDR_W'(4 * i);
         d[32*i +: 32] = 32'hA000_0000 | {12'h000, wa[19:0]};
      end
      return d;
   endfunction

   // I-cache model, mid-cycle: one response per accepted request
   logic              pend = 1'b0;
   int                cnt = 0;
   logic [ADDR_W-1:0] raddr = '0;
   always @(negedge CLK) begin
      if (RST) begin
         pend = 1'b0;
         ICACHE_RESP_VALID = 1'b0;
      end else begin
         ICACHE_RESP_VALID = 1'b0;
         if (ICACHE_REQ_VALID && ICACHE_REQ_READY) begin
            req_log.push_back(ICACHE_REQ_ADDR);
            pend  = 1'b1;
            cnt   = resp_delay;
            raddr = ICACHE_REQ_ADDR;
         end else if (pend) begin
            if (cnt <= 1) begin
               pend              = 1'b0;
               ICACHE_RESP_VALID = 1'b1;
               ICACHE_RESP_DATA  = line_data(raddr);
               ICACHE_RESP_XCPT  = (raddr == 40'h6000);
            end else begin
               cnt = cnt - 1;
            end
         end
      end
   end

   // Monitor: compare every head entry that decode consumes
   always @(negedge CLK) begin
      if (!RST && FETCH_VALID && DEC_READY && !WB_REDIRECT && !EXE_REDIRECT && !DEC_REDIRECT) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pop: got pc 0x%0h inst 0x%0h, required no entry", FETCH_PC, FETCH_INST);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("pop_pc",   64'(FETCH_PC), 64'(e.pc));
            chk("pop_inst", 64'(FETCH_INST), 64'(e.inst));
            chk("pop_mis",  64'(FETCH_XCPT_MISALIGNED), 64'(e.mis));
            chk("pop_xif",  64'(FETCH_XCPT_IF), 64'(e.xif));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic expect_ent(input logic [ADDR_W-1:0] pc, input logic [31:0] inst,
                             input logic mis, input logic xif);
      ent_t e;
      e.pc = pc; e.inst = inst; e.mis = mis; e.xif = xif;
      exp_q.push_back(e);
   endtask

   task automatic pop_all(input int budget);
      int k;
      k = 0;
      DEC_READY = 1'b1;
      while (exp_q.size() != 0 && k < budget) begin
         step();
         k++;
      end
      DEC_READY = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL pop_timeout: %0d entries still pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic redirect(input int which, input logic [ADDR_W-1:0] a);
      case (which)
         0:       begin WB_REDIRECT  = 1'b1; WB_ADDR  = a; end
         1:       begin EXE_REDIRECT = 1'b1; EXE_ADDR = a; end
         default: begin DEC_REDIRECT = 1'b1; DEC_ADDR = a; end
      endcase
      step();
      WB_REDIRECT = 1'b0; EXE_REDIRECT = 1'b0; DEC_REDIRECT = 1'b0;
   endtask

   task automatic wait_req(input int n0);
      int k;
      k = 0;
      while (req_log.size() <= n0 && k < 50) begin
         step();
         k++;
      end
      chk("req_seen", 64'(req_log.size() > n0), 64'd1);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk(name, 64'(|{ICACHE_REQ_VALID, ICACHE_REQ_ADDR, ICACHE_REQ_KILL, ICACHE_INVALIDATE,
                       FETCH_VALID, FETCH_PC, FETCH_INST, FETCH_XCPT_MISALIGNED, FETCH_XCPT_IF}), 64'd0);
   endtask

   initial begin
      int n0, n1;
      step(3);
      chk_outputs_zero("reset_outputs");
      RST = 1'b0;

      // Boot: first line then next line fetched, queue holds 4 entries
      step(30);
      chk("boot_req_count", 64'(req_log.size()), 64'd2);
      chk("boot_req0", 64'(req_log[0]), 64'h1000);
      chk("boot_req1", 64'(req_log[1]), 64'h1010);
      chk("boot_head_pc", 64'(FETCH_PC), 64'h1000);
      chk("boot_head_inst", 64'(FETCH_INST), 64'hA000_1000);

      // Full queue held with decode stalled, then drained without loss
      expect_ent(40'h1000, 32'hA000_1000, 0, 0);
      expect_ent(40'h1004, 32'hA000_1004, 0, 0);
      expect_ent(40'h1008, 32'hA000_1008, 0, 0);
      expect_ent(40'h100C, 32'hA000_100C, 0, 0);
      expect_ent(40'h1010, 32'hA000_1010, 0, 0);
      expect_ent(40'h1014, 32'hA000_1014, 0, 0);
      expect_ent(40'h1018, 32'hA000_1018, 0, 0);
      expect_ent(40'h101C, 32'hA000_101C, 0, 0);
      pop_all(50);
      step(30);
      chk("seq_req_count", 64'(req_log.size()), 64'd4);
      chk("seq_req2", 64'(req_log[2]), 64'h1020);
      chk("seq_req3", 64'(req_log[3]), 64'h1030);
      chk("seq_head_pc", 64'(FETCH_PC), 64'h1020);

      // EXE redirect while waiting on a slow line: kill, drain, refetch
      resp_delay = 6;
      n0 = req_log.size();
      redirect(2, 40'h7000);
      wait_req(n0);
      chk("slow_req_addr", 64'(req_log[n0]), 64'h7000);
      EXE_REDIRECT = 1'b1; EXE_ADDR = 40'h2004;
      #1;
      chk("kill_pulse", 64'(ICACHE_REQ_KILL), 64'd1);
      chk("req_valid_on_redirect", 64'(ICACHE_REQ_VALID), 64'd0);
      step();
      EXE_REDIRECT = 1'b0;
      #1;
      chk("kill_one_cycle", 64'(ICACHE_REQ_KILL), 64'd0);
      expect_ent(40'h2004, 32'hA000_2004, 0, 0);
      expect_ent(40'h2008, 32'hA000_2008, 0, 0);
      expect_ent(40'h200C, 32'hA000_200C, 0, 0);
      expect_ent(40'h2010, 32'hA000_2010, 0, 0);
      pop_all(100);
      chk("refetch_req_addr", 64'(req_log[n0+1]), 64'h2000);
      resp_delay = 2;
      step(30);

      // WB beats DEC; FENCE_I alongside a redirect does not invalidate
      n0 = req_log.size();
      WB_REDIRECT = 1'b1; WB_ADDR = 40'h3000;
      DEC_REDIRECT = 1'b1; DEC_ADDR = 40'h4000;
      FENCE_I = 1'b1;
      #1;
      chk("inval_masked", 64'(ICACHE_INVALIDATE), 64'd0);
      step();
      WB_REDIRECT = 1'b0; DEC_REDIRECT = 1'b0; FENCE_I = 1'b0;
      expect_ent(40'h3000, 32'hA000_3000, 0, 0);
      expect_ent(40'h3004, 32'hA000_3004, 0, 0);
      expect_ent(40'h3008, 32'hA000_3008, 0, 0);
      expect_ent(40'h300C, 32'hA000_300C, 0, 0);
      pop_all(60);
      chk("wb_req_addr", 64'(req_log[n0]), 64'h3000);
      step(30);

      // Bare FENCE_I: invalidate, refetch current line, queue kept
      n1 = req_log.size();
      FENCE_I = 1'b1;
      #1;
      chk("inval_pulse", 64'(ICACHE_INVALIDATE), 64'd1);
      step();
      FENCE_I = 1'b0;
      step(20);
      chk("fence_req_count", 64'(req_log.size()), 64'(n1 + 1));
      chk("fence_req_addr", 64'(req_log[n1]), 64'h3020);
      chk("fence_queue_kept", 64'(FETCH_PC), 64'h3010);

      // Misaligned target: one exception entry, no request, halted
      n0 = req_log.size();
      redirect(2, 40'h5002);
      expect_ent(40'h5002, 32'h0, 1, 0);
      pop_all(20);
      step(20);
      chk("mis_no_req", 64'(req_log.size()), 64'(n0));
      chk("mis_halted", 64'(FETCH_VALID), 64'd0);

      // Faulting line: one fetch-fault entry, then halted
      n0 = req_log.size();
      redirect(2, 40'h6000);
      expect_ent(40'h6000, 32'h0, 0, 1);
      pop_all(40);
      step(20);
      chk("xif_req_count", 64'(req_log.size()), 64'(n0 + 1));
      chk("xif_req_addr", 64'(req_log[n0]), 64'h6000);
      chk("xif_halted", 64'(FETCH_VALID), 64'd0);

      // Reset while waiting, then a clean reboot
      resp_delay = 8;
      n0 = req_log.size();
      redirect(2, 40'h8000);
      wait_req(n0);
      RST = 1'b1;
      #1;
      chk_outputs_zero("mid_wait_reset");
      step(2);
      chk_outputs_zero("held_reset");
      RST = 1'b0;
      resp_delay = 2;
      expect_ent(40'h1000, 32'hA000_1000, 0, 0);
      expect_ent(40'h1004, 32'hA000_1004, 0, 0);
      expect_ent(40'h1008, 32'hA000_1008, 0, 0);
      expect_ent(40'h100C, 32'hA000_100C, 0, 0);
      pop_all(60);
      chk("reboot_req_addr", 64'(req_log[n0+1]), 64'h1000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
